// File: rtl/pci_arb_pkg.sv
// rtl/pci_arb_pkg.sv - shared types and helpers for the PCI round-robin arbiter
package pci_arb_pkg;

  typedef enum logic [1:0] {PARK, GAP, GRANT, BUSY} arb_state_e;

  localparam int TO_W = 8;

  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pci_rr_pick.sv
// rtl/pci_rr_pick.sv - rotating priority encoder, scans ptr+1 .. ptr (ptr itself last)
module pci_rr_pick #(
  parameter int N  = 3,
  parameter int OW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [OW-1:0] ptr,
  output logic          any,
  output logic [OW-1:0] idx
);

  int   cand;
  logic found;

  always_comb begin
    any   = |req;
    idx   = ptr;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand[OW-1:0];
      end
    end
  end

endmodule

// File: rtl/pci_rr_arbiter.sv
// rtl/pci_rr_arbiter.sv - N-master PCI bus arbiter: round-robin, parking, hidden arbitration, start timeout
module pci_rr_arbiter
  import pci_arb_pkg::*;
#(
  parameter int N_MASTERS     = 3,
  parameter int PARK_EN       = 1,
  parameter int PARK_MASTER   = 0,
  parameter int START_TIMEOUT = 16,
  localparam int OW           = clog2_min1(N_MASTERS)
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [N_MASTERS-1:0] Req_n,
  input  logic                 Frame_n,
  input  logic                 IRDY_n,
  output logic [N_MASTERS-1:0] Gnt_n,
  output logic [OW-1:0]        Owner,
  output logic                 Gnt_Valid,
  output logic                 Start_Timeout
);

  localparam logic [OW-1:0]        PARK_IDX = OW'(PARK_MASTER);
  localparam logic [TO_W-1:0]      TO_LAST  = TO_W'(START_TIMEOUT - 1);
  localparam logic [N_MASTERS-1:0] ONE      = {{(N_MASTERS-1){1'b0}}, 1'b1};

  arb_state_e            state_q, state_d;
  logic [OW-1:0]         owner_q, owner_d, ptr_q, ptr_d;
  logic [TO_W-1:0]       cnt_q, cnt_d;
  logic                  bus_idle_q;
  logic [N_MASTERS-1:0]  gnt_n_q, gnt_n_d, gnt_oh_d;
  logic                  valid_q, valid_d, to_q, to_d;

  logic                  bus_idle, tx_start, owner_req;
  logic [N_MASTERS-1:0]  req, own_oh, pick_req;
  logic                  pick_any;
  logic [OW-1:0]         pick_idx;

  assign bus_idle  = Frame_n & IRDY_n;
  assign tx_start  = bus_idle_q & ~Frame_n;
  assign req       = ~Req_n;
  assign own_oh    = ONE << owner_q;
  assign owner_req = |(req & own_oh);
  // While someone owns the bus only the other masters compete.
  assign pick_req  = (state_q == GRANT || state_q == BUSY) ? (req & ~own_oh) : req;

  pci_rr_pick #(.N(N_MASTERS), .OW(OW)) u_pick (
    .req (pick_req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= PARK;
      owner_q    <= PARK_IDX;
      ptr_q      <= PARK_IDX;
      cnt_q      <= '0;
      bus_idle_q <= 1'b1;
      gnt_n_q    <= '1;
      valid_q    <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      bus_idle_q <= bus_idle;
      gnt_n_q    <= gnt_n_d;
      valid_q    <= valid_d;
      to_q       <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    unique case (state_q)
      PARK: begin
        owner_d = PARK_IDX;
        if (pick_any) begin
          owner_d = pick_idx;
          ptr_d   = pick_idx;
          cnt_d   = '0;
          state_d = (PARK_EN != 0 && pick_idx == PARK_IDX) ? GRANT : GAP;
        end
      end
      GAP: begin
        state_d = GRANT;
        cnt_d   = '0;
      end
      GRANT: begin
        if (tx_start) begin
          state_d = BUSY;
          cnt_d   = '0;
        end else if (!owner_req && bus_idle) begin
          if (pick_any) begin
            state_d = GAP;
            owner_d = pick_idx;
            ptr_d   = pick_idx;
          end else begin
            state_d = PARK;
            owner_d = PARK_IDX;
          end
        end else if (bus_idle) begin
          if (cnt_q == TO_LAST) begin
            if (pick_any) begin
              to_d    = 1'b1;
              state_d = GAP;
              owner_d = pick_idx;
              ptr_d   = pick_idx;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      BUSY: begin
        if (pick_any) begin
          state_d = GAP;
          owner_d = pick_idx;
          ptr_d   = pick_idx;
        end else if (bus_idle) begin
          if (owner_req) begin
            state_d = GRANT;
            cnt_d   = '0;
          end else begin
            state_d = PARK;
            owner_d = PARK_IDX;
          end
        end
      end
      default: state_d = PARK;
    endcase
  end

  always_comb begin
    gnt_oh_d = ONE << owner_d;
    gnt_n_d  = '1;
    unique case (state_d)
      PARK:        if (PARK_EN != 0) gnt_n_d = ~gnt_oh_d;
      GRANT, BUSY: gnt_n_d = ~gnt_oh_d;
      default:     gnt_n_d = '1;
    endcase
    valid_d = ~&gnt_n_d;
  end

  assign Gnt_n         = gnt_n_q;
  assign Owner         = owner_q;
  assign Gnt_Valid     = valid_q;
  assign Start_Timeout = to_q;

endmodule
